// File: rtl/scmp_boot_pkg.sv
// rtl/scmp_boot_pkg.sv - shared state type and data width for the SC/MP boot sequencer
package scmp_boot_pkg;

    localparam int DATA_W = 8;

    typedef enum logic [2:0] {
        LOCKWAIT,
        COPY,
        DRAIN,
        VERIFY,
        FAULT,
        RUN
    } boot_state_t;

endpackage

// File: rtl/scmp_debounce.sv
// rtl/scmp_debounce.sv - 2-flop synchronizer plus stable-sample counter for a raw button
module scmp_debounce #(
    parameter int   CYCLES    = 20000,
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk_1m,
    input  logic rst_n,
    input  logic din,
    output logic dout
);

    localparam int CNT_W = $clog2(CYCLES + 1);

    logic             sync_1;
    logic             sync_2;
    logic [CNT_W-1:0] cnt;

    // dout only follows once CYCLES consecutive synchronized samples disagree with it
    always_ff @(posedge clk_1m or negedge rst_n) begin
        if (!rst_n) begin
            sync_1 <= RESET_VAL;
            sync_2 <= RESET_VAL;
            cnt    <= '0;
            dout   <= RESET_VAL;
        end else begin
            sync_1 <= din;
            sync_2 <= sync_1;
            if (sync_2 == dout) begin
                cnt <= '0;
            end else if (cnt == CNT_W'(CYCLES - 1)) begin
                dout <= sync_2;
                cnt  <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/scmp_boot_sequencer.sv
// rtl/scmp_boot_sequencer.sv - PLL-lock wait, ROM-to-RAM boot copy and CPU reset release
// Optional read-back check of RAM against ROM when BOOT_VERIFY_EN is defined.
module scmp_boot_sequencer
    import scmp_boot_pkg::*;
#(
    parameter int ADDR_W      = 12,
    parameter int LOCK_CYCLES = 1000,
    parameter int DEB_CYCLES  = 20000
) (
    input  logic              clk_1m,
    input  logic              rst_n,
    input  logic              pll_lock,
    input  logic              btn_n,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_q,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_data,
    output logic              ram_wren,
    output logic              bus_grant,
    output logic              cpu_rst_n,
    output logic              busy,
    output logic              boot_err
`ifdef BOOT_VERIFY_EN
    ,
    input  logic [DATA_W-1:0] ram_q
`endif
);

    localparam int                LCW       = $clog2(LOCK_CYCLES + 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

    boot_state_t state;
    logic [LCW-1:0] lock_cnt;
    logic lock_m;
    logic lock_s;
    logic btn_deb;
    logic btn_deb_d;
    logic restart;
    logic abort;

    always_ff @(posedge clk_1m or negedge rst_n) begin
        if (!rst_n) begin
            lock_m    <= 1'b0;
            lock_s    <= 1'b0;
            btn_deb_d <= 1'b1;
        end else begin
            lock_m    <= pll_lock;
            lock_s    <= lock_m;
            btn_deb_d <= btn_deb;
        end
    end

    scmp_debounce #(
        .CYCLES    (DEB_CYCLES),
        .RESET_VAL (1'b1)
    ) u_btn_deb (
        .clk_1m (clk_1m),
        .rst_n  (rst_n),
        .din    (btn_n),
        .dout   (btn_deb)
    );

    assign restart = btn_deb_d & ~btn_deb;
    assign abort   = restart | ~lock_s;

    // Read data goes straight to the RAM port; gated so the bus idles at zero
    assign ram_data = ram_wren ? rom_q : '0;

`ifdef BOOT_VERIFY_EN
    logic cmp_vld;
    logic vfy_done;
    logic boot_err_r;
    assign boot_err = boot_err_r;
`else
    assign boot_err = 1'b0;
`endif

    always_ff @(posedge clk_1m or negedge rst_n) begin
        if (!rst_n) begin
            state     <= LOCKWAIT;
            lock_cnt  <= '0;
            rom_addr  <= '0;
            ram_addr  <= '0;
            ram_wren  <= 1'b0;
            bus_grant <= 1'b1;
            cpu_rst_n <= 1'b0;
            busy      <= 1'b0;
`ifdef BOOT_VERIFY_EN
            cmp_vld    <= 1'b0;
            vfy_done   <= 1'b0;
            boot_err_r <= 1'b0;
`endif
        end else if (abort) begin
            // Lock loss and button restart share one path so coincident events match either alone
            state     <= LOCKWAIT;
            lock_cnt  <= '0;
            rom_addr  <= '0;
            ram_addr  <= '0;
            ram_wren  <= 1'b0;
            bus_grant <= 1'b1;
            cpu_rst_n <= 1'b0;
            busy      <= 1'b1;
`ifdef BOOT_VERIFY_EN
            cmp_vld  <= 1'b0;
            vfy_done <= 1'b0;
            if (restart) begin
                boot_err_r <= 1'b0;
            end
`endif
        end else begin
            case (state)
                LOCKWAIT: begin
                    busy     <= 1'b1;
                    ram_wren <= 1'b0;
                    if (lock_cnt == LCW'(LOCK_CYCLES - 1)) begin
                        state    <= COPY;
                        lock_cnt <= '0;
                        rom_addr <= '0;
                    end else begin
                        lock_cnt <= lock_cnt + LCW'(1);
                    end
                end
                COPY: begin
                    ram_addr <= rom_addr;
                    ram_wren <= 1'b1;
                    rom_addr <= rom_addr + ADDR_W'(1);
                    if (rom_addr == ADDR_LAST) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    ram_wren <= 1'b0;
                    rom_addr <= '0;
                    ram_addr <= '0;
`ifdef BOOT_VERIFY_EN
                    state    <= VERIFY;
                    cmp_vld  <= 1'b0;
                    vfy_done <= 1'b0;
`else
                    state     <= RUN;
                    bus_grant <= 1'b0;
                    cpu_rst_n <= 1'b1;
                    busy      <= 1'b0;
`endif
                end
`ifdef BOOT_VERIFY_EN
                VERIFY: begin
                    if (cmp_vld && (ram_q != rom_q)) begin
                        state      <= FAULT;
                        boot_err_r <= 1'b1;
                        busy       <= 1'b0;
                        cmp_vld    <= 1'b0;
                    end else if (vfy_done) begin
                        state     <= RUN;
                        bus_grant <= 1'b0;
                        cpu_rst_n <= 1'b1;
                        busy      <= 1'b0;
                        cmp_vld   <= 1'b0;
                        rom_addr  <= '0;
                        ram_addr  <= '0;
                    end else begin
                        rom_addr <= rom_addr + ADDR_W'(1);
                        ram_addr <= rom_addr + ADDR_W'(1);
                        cmp_vld  <= 1'b1;
                        if (rom_addr == ADDR_LAST) begin
                            vfy_done <= 1'b1;
                        end
                    end
                end
                FAULT: begin
                    bus_grant <= 1'b1;
                    cpu_rst_n <= 1'b0;
                    busy      <= 1'b0;
                end
`endif
                RUN: begin
                    bus_grant <= 1'b0;
                    cpu_rst_n <= 1'b1;
                    busy      <= 1'b0;
                end
                default: begin
                    state <= LOCKWAIT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_scmp_boot_sequencer.sv
// tb/tb_scmp_boot_sequencer.sv - scoreboard bench for scmp_boot_sequencer, BOOT_VERIFY_EN optional
`timescale 1ns/1ps
module tb_scmp_boot_sequencer;

    localparam int ADDR_W      = 4;
    localparam int LOCK_CYCLES = 8;
    localparam int DEB_CYCLES  = 4;
    localparam int SYNC        = 2;
    localparam int COPY_RUN    = (1 << ADDR_W) + 1;
`ifdef BOOT_VERIFY_EN
    localparam int VFY = (1 << ADDR_W) + 1;
`else
    localparam int VFY = 0;
`endif
    localparam int T_RUN   = SYNC + LOCK_CYCLES + COPY_RUN + VFY;
    localparam int T_ABORT = SYNC + DEB_CYCLES + 1;

    logic              clk_1m = 1'b0;
    logic              rst_n;
    logic              pll_lock;
    logic              btn_n;
    logic [ADDR_W-1:0] rom_addr;
    logic [7:0]        rom_q = 8'h00;
    logic [ADDR_W-1:0] ram_addr;
    logic [7:0]        ram_data;
    logic              ram_wren;
    logic              bus_grant;
    logic              cpu_rst_n;
    logic              busy;
    logic              boot_err;

    int n_checks;
    int n_pass;
    logic [11:0] sb[$];

    always #5 clk_1m = ~clk_1m;

    always @(posedge clk_1m) rom_q <= {4'h0, rom_addr} ^ 8'hA5;

`ifdef BOOT_VERIFY_EN
    logic [7:0] ram_q = 8'h00;
    logic [7:0] mem [16];
    logic       corrupt = 1'b0;
    always @(posedge clk_1m) begin
        if (ram_wren) mem[ram_addr] <= (corrupt && ram_addr == 4'd9) ? ~ram_data : ram_data;
        ram_q <= mem[ram_addr];
    end
`endif

    scmp_boot_sequencer #(
        .ADDR_W      (ADDR_W),
        .LOCK_CYCLES (LOCK_CYCLES),
        .DEB_CYCLES  (DEB_CYCLES)
    ) dut (
        .clk_1m    (clk_1m),
        .rst_n     (rst_n),
        .pll_lock  (pll_lock),
        .btn_n     (btn_n),
        .rom_addr  (rom_addr),
        .rom_q     (rom_q),
        .ram_addr  (ram_addr),
        .ram_data  (ram_data),
        .ram_wren  (ram_wren),
        .bus_grant (bus_grant),
        .cpu_rst_n (cpu_rst_n),
        .busy      (busy),
        .boot_err  (boot_err)
`ifdef BOOT_VERIFY_EN
        ,
        .ram_q     (ram_q)
`endif
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    task automatic tick();
        @(posedge clk_1m);
        #1;
    endtask

    task automatic push_copy(input int n);
        for (int i = 0; i < n; i++) sb.push_back({4'(i), 8'(i) ^ 8'hA5});
    endtask

    task automatic monitor();
        logic [11:0] exp_w;
        forever begin
            @(negedge clk_1m);
            if (rst_n && ram_wren) begin
                check("wren_grant", {31'b0, bus_grant}, 32'd1);
                if (sb.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_write: addr %0h data %0h, none expected", ram_addr, ram_data);
                end else begin
                    exp_w = sb.pop_front();
                    check("ram_write", {20'b0, ram_addr, ram_data}, {20'b0, exp_w});
                end
            end
        end
    endtask

    task automatic expect_run_at(input int n, input string tag);
        repeat (n - 1) tick();
        check({tag, "_pre_cpu_rst_n"}, {31'b0, cpu_rst_n}, 32'd0);
        check({tag, "_pre_bus_grant"}, {31'b0, bus_grant}, 32'd1);
        tick();
        check({tag, "_run_cpu_rst_n"}, {31'b0, cpu_rst_n}, 32'd1);
        check({tag, "_run_bus_grant"}, {31'b0, bus_grant}, 32'd0);
        check({tag, "_run_busy"}, {31'b0, busy}, 32'd0);
        check({tag, "_run_boot_err"}, {31'b0, boot_err}, 32'd0);
        check({tag, "_writes_done"}, sb.size(), 32'd0);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_rom_addr"}, {28'b0, rom_addr}, 32'd0);
        check({tag, "_ram_addr"}, {28'b0, ram_addr}, 32'd0);
        check({tag, "_ram_data"}, {24'b0, ram_data}, 32'd0);
        check({tag, "_ram_wren"}, {31'b0, ram_wren}, 32'd0);
        check({tag, "_bus_grant"}, {31'b0, bus_grant}, 32'd1);
        check({tag, "_cpu_rst_n"}, {31'b0, cpu_rst_n}, 32'd0);
        check({tag, "_busy"}, {31'b0, busy}, 32'd0);
        check({tag, "_boot_err"}, {31'b0, boot_err}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst_n    = 1'b0;
        pll_lock = 1'b1;
        btn_n    = 1'b1;
        fork
            monitor();
        join_none
        repeat (3) tick();
        check_reset_vals("reset");

        // 1: lock stable from reset release, full copy then release
        push_copy(16);
        rst_n = 1'b1;
        expect_run_at(T_RUN, "t1");

        // 2: lock loss from RUN, short lock pulse, then full relock
        pll_lock = 1'b0;
        repeat (SYNC) tick();
        check("t2_loss_hold", {31'b0, cpu_rst_n}, 32'd1);
        tick();
        check("t2_loss_cpu_rst_n", {31'b0, cpu_rst_n}, 32'd0);
        check("t2_loss_bus_grant", {31'b0, bus_grant}, 32'd1);
        check("t2_loss_busy", {31'b0, busy}, 32'd1);
        repeat (3) tick();
        pll_lock = 1'b1;
        repeat (5) tick();
        pll_lock = 1'b0;
        repeat (8) tick();
        check("t2_pulse_bus_grant", {31'b0, bus_grant}, 32'd1);
        check("t2_pulse_cpu_rst_n", {31'b0, cpu_rst_n}, 32'd0);
        check("t2_pulse_rom_addr", {28'b0, rom_addr}, 32'd0);
        push_copy(16);
        pll_lock = 1'b1;
        expect_run_at(T_RUN, "t2");

        // 3: lock lost while copy address 7 is issued (drop lands SYNC cycles later)
        pll_lock = 1'b0;
        repeat (6) tick();
        push_copy(7);
        pll_lock = 1'b1;
        repeat (SYNC + LOCK_CYCLES + 7 - SYNC) tick();
        pll_lock = 1'b0;
        repeat (SYNC) tick();
        check("t3_rom_addr7", {28'b0, rom_addr}, 32'd7);
        check("t3_wren_before", {31'b0, ram_wren}, 32'd1);
        tick();
        check("t3_wren_after", {31'b0, ram_wren}, 32'd0);
        check("t3_bus_grant", {31'b0, bus_grant}, 32'd1);
        check("t3_cpu_rst_n", {31'b0, cpu_rst_n}, 32'd0);
        check("t3_rom_addr0", {28'b0, rom_addr}, 32'd0);
        repeat (4) tick();
        push_copy(16);
        pll_lock = 1'b1;
        expect_run_at(T_RUN, "t3");

        // 4: short button glitch ignored, held press restarts the sequence
        btn_n = 1'b0;
        repeat (DEB_CYCLES - 1) tick();
        btn_n = 1'b1;
        repeat (10) tick();
        check("t4_glitch_cpu_rst_n", {31'b0, cpu_rst_n}, 32'd1);
        check("t4_glitch_bus_grant", {31'b0, bus_grant}, 32'd0);
        btn_n = 1'b0;
        repeat (T_ABORT - 1) tick();
        check("t4_press_hold", {31'b0, cpu_rst_n}, 32'd1);
        btn_n = 1'b1;
        tick();
        check("t4_press_cpu_rst_n", {31'b0, cpu_rst_n}, 32'd0);
        check("t4_press_bus_grant", {31'b0, bus_grant}, 32'd1);
        check("t4_press_busy", {31'b0, busy}, 32'd1);
        push_copy(16);
        expect_run_at(LOCK_CYCLES + COPY_RUN + VFY, "t4");

`ifdef BOOT_VERIFY_EN
        // 5: corrupted RAM[9] caught on read-back, button clears the fault
        begin
            int n;
            corrupt = 1'b1;
            push_copy(16);
            btn_n = 1'b0;
            repeat (T_ABORT - 1) tick();
            btn_n = 1'b1;
            n = T_ABORT - 1;
            while (!boot_err && n < 200) begin
                tick();
                n++;
            end
            check("t5_err_latency", n, T_ABORT + LOCK_CYCLES + COPY_RUN + 1 + 9 + 1);
            check("t5_fault_cpu_rst_n", {31'b0, cpu_rst_n}, 32'd0);
            check("t5_fault_bus_grant", {31'b0, bus_grant}, 32'd1);
            check("t5_fault_busy", {31'b0, busy}, 32'd0);
            repeat (10) tick();
            check("t5_sticky_err", {31'b0, boot_err}, 32'd1);
            check("t5_sticky_cpu_rst_n", {31'b0, cpu_rst_n}, 32'd0);
            corrupt = 1'b0;
            push_copy(16);
            btn_n = 1'b0;
            repeat (T_ABORT - 1) tick();
            btn_n = 1'b1;
            tick();
            check("t5_err_cleared", {31'b0, boot_err}, 32'd0);
            expect_run_at(LOCK_CYCLES + COPY_RUN + VFY, "t5");
        end
`endif

        // 6: asynchronous reset in the middle of a copy
        pll_lock = 1'b0;
        repeat (6) tick();
        push_copy(3);
        pll_lock = 1'b1;
        repeat (SYNC + LOCK_CYCLES + 4) tick();
        check("t6_mid_wren", {31'b0, ram_wren}, 32'd1);
        check("t6_mid_ram_addr", {28'b0, ram_addr}, 32'd3);
        #2 rst_n = 1'b0;
        #1;
        check_reset_vals("t6_async");
        repeat (3) tick();
        check("t6_all_writes_seen", sb.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
